// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the DataMemory arbiter: port identifiers and the
// layout of the one-entry response pipeline.
package dmem_arbiter_pkg;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic owner;
    logic is_read;
    logic in_range;
  } rsp_t;

  // Only words below 2^aw exist in DataMemory; any higher address bit set is an error.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
    return ((addr >> aw) == 32'd0);
  endfunction

endpackage

// File: rtl/dmem_rr_starve.sv
// Starvation guard for a fixed-priority two-requester arbiter: counts
// consecutive high-priority grants while the low-priority side waits.
module dmem_rr_starve #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_b_req,
  input  logic i_a_gnt,
  input  logic i_b_gnt,
  output logic o_force_b
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_cnt;

  assign o_force_b = (r_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || !i_b_req || i_b_gnt) begin
      r_cnt <= 4'd0;
    end else if (i_a_gnt && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port DataMemory: port A has fixed
// priority, port B is forced through after STARVE_LIMIT consecutive A grants.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  logic        w_force_b;
  logic        w_a_gnt;
  logic        w_b_gnt;
  logic        w_any_gnt;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_in_range;
  rsp_t        w_rsp;

  rsp_t        r_rsp_p1;
  logic        r_vld_p1;
  logic        w_a_hit;
  logic        w_b_hit;
  logic [31:0] w_rdata;

  dmem_rr_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .i_b_req  (b_req),
    .i_a_gnt  (w_a_gnt),
    .i_b_gnt  (w_b_gnt),
    .o_force_b(w_force_b)
  );

  // Grants are suppressed during reset so nothing is issued on the reset edge.
  always_comb begin
    w_a_gnt    = a_req & ~w_force_b & ~rst;
    w_b_gnt    = b_req & (~a_req | w_force_b) & ~rst;
    w_any_gnt  = w_a_gnt | w_b_gnt;
    w_we       = w_b_gnt ? b_we    : a_we;
    w_addr     = w_b_gnt ? b_addr  : a_addr;
    w_wdata    = w_b_gnt ? b_wdata : a_wdata;
    w_in_range = addr_in_range(w_addr, ADDR_WIDTH);
    w_rsp      = '{owner: (w_b_gnt ? PORT_B : PORT_A), is_read: ~w_we, in_range: w_in_range};
  end

  assign a_gnt = w_a_gnt;
  assign b_gnt = w_b_gnt;

  // ---- Issue stage (E0): command registered toward memory ----
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we   <= 1'b0;
      mem_addr <= 32'd0;
      mem_din  <= 32'd0;
      r_vld_p1 <= 1'b0;
      r_rsp_p1 <= '0;
    end else begin
      r_vld_p1 <= w_any_gnt;
      if (w_any_gnt) begin
        mem_we   <= w_we & w_in_range;
        mem_addr <= w_addr;
        mem_din  <= w_wdata;
        r_rsp_p1 <= w_rsp;
      end else begin
        mem_we   <= 1'b0;
      end
    end
  end

  always_comb begin
    w_a_hit = r_vld_p1 & (r_rsp_p1.owner == PORT_A);
    w_b_hit = r_vld_p1 & (r_rsp_p1.owner == PORT_B);
    w_rdata = (r_rsp_p1.is_read & r_rsp_p1.in_range) ? mem_dout : 32'd0;
  end

  // ---- Response stage (E1): memory sampled its negedge result ----
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      a_rdata  <= 32'd0;
      a_err    <= 1'b0;
      b_rvalid <= 1'b0;
      b_rdata  <= 32'd0;
      b_err    <= 1'b0;
    end else begin
      a_rvalid <= w_a_hit;
      a_rdata  <= w_a_hit ? w_rdata : 32'd0;
      a_err    <= w_a_hit & ~r_rsp_p1.in_range;
      b_rvalid <= w_b_hit;
      b_rdata  <= w_b_hit ? w_rdata : 32'd0;
      b_err    <= w_b_hit & ~r_rsp_p1.in_range;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural negedge-clocked
// DataMemory (1024 words) attached to the memory command port.
module tb_dmem_arbiter;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, a_gnt, a_rvalid, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_req, b_we, b_gnt, b_rvalid, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_fill;
  logic [31:0] mem [1024];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Memory contents: word i holds 0xA5000000 | i after the fill
  always @(negedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      mem_dout <= 32'd0;
    end else begin
      if (mem_we) mem[mem_addr[AW-1:0]] <= mem_din;
      mem_dout <= mem[mem_addr[AW-1:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic hist [12];

  initial begin
    rst = 1'b1; mem_fill = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10; a_wdata = 32'd0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h30; b_wdata = 32'd0;

    // Reset with both ports requesting
    cyc();
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    cyc();
    chk("rst2_a_gnt", a_gnt, 0);
    chk("rst2_b_gnt", b_gnt, 0);
    rst = 1'b0; mem_fill = 1'b0;
    #1;
    chk("first_a_gnt", a_gnt, 1);
    chk("first_b_gnt", b_gnt, 0);
    cyc();
    chk("first_mem_addr", mem_addr, 32'h10);
    chk("first_mem_we", mem_we, 0);
    a_req = 1'b0; b_req = 1'b0;
    cyc();
    chk("first_a_rvalid", a_rvalid, 1);
    chk("first_a_rdata", a_rdata, 32'hA500_0010);

    // A write then read-after-write at 0x10
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h10; a_wdata = 32'hDEAD_BEEF;
    cyc();
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_din", mem_din, 32'hDEAD_BEEF);
    chk("wr_a_rvalid0", a_rvalid, 0);
    a_we = 1'b0;
    cyc();
    chk("rd_mem_we", mem_we, 0);
    chk("wr_a_rvalid", a_rvalid, 1);
    chk("wr_a_rdata", a_rdata, 0);
    chk("wr_a_err", a_err, 0);
    a_req = 1'b0;
    cyc();
    chk("raw_a_rvalid", a_rvalid, 1);
    chk("raw_a_rdata", a_rdata, 32'hDEAD_BEEF);
    chk("raw_a_err", a_err, 0);
    cyc();
    chk("raw_a_rvalid_end", a_rvalid, 0);

    // Contention: expected grants A,A,A,A,B,A,A,A,A,B
    a_addr = 32'h20; b_addr = 32'h30; b_we = 1'b0;
    for (int i = 0; i < 12; i++) begin
      a_req = (i < 10); b_req = (i < 10);
      #1;
      hist[i] = (i < 10) && (i % 5 == 4);
      chk($sformatf("cont_b_gnt_%0d", i), b_gnt, hist[i]);
      chk($sformatf("cont_a_gnt_%0d", i), a_gnt, (i < 10) && !hist[i]);
      if (i >= 2) begin
        chk($sformatf("cont_b_rvalid_%0d", i), b_rvalid, hist[i-2]);
        if (hist[i-2]) chk($sformatf("cont_b_rdata_%0d", i), b_rdata, 32'hA500_0030);
      end
      cyc();
    end

    // Out-of-range B write must not reach memory
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h400; b_wdata = 32'h1234;
    cyc();
    chk("oor_mem_we", mem_we, 0);
    b_req = 1'b0;
    cyc();
    chk("oor_b_rvalid", b_rvalid, 1);
    chk("oor_b_err", b_err, 1);
    chk("oor_b_rdata", b_rdata, 0);
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h0;
    cyc();
    b_req = 1'b0;
    cyc();
    chk("alias_b_rvalid", b_rvalid, 1);
    chk("alias_b_rdata", b_rdata, 32'hA500_0000);
    chk("alias_b_err", b_err, 0);

    // Reset while an A read is in flight, with an A write pending
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10;
    cyc();
    a_we = 1'b1; a_addr = 32'h40; a_wdata = 32'h5555_5555; rst = 1'b1;
    #1;
    chk("midrst_a_gnt", a_gnt, 0);
    cyc();
    chk("midrst_a_rvalid", a_rvalid, 0);
    chk("midrst_mem_we", mem_we, 0);
    rst = 1'b0; a_req = 1'b0;
    cyc();
    chk("midrst_a_rvalid2", a_rvalid, 0);
    chk("midrst_mem_we2", mem_we, 0);
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h40;
    cyc();
    a_req = 1'b0;
    cyc();
    chk("midrst_rb_rvalid", a_rvalid, 1);
    chk("midrst_rb_rdata", a_rdata, 32'hA500_0040);

    // Idle hold: command register holds, nothing issued, no forced B
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("idle_mem_we_%0d", i), mem_we, 0);
      chk($sformatf("idle_mem_addr_%0d", i), mem_addr, 32'h40);
      chk($sformatf("idle_a_rvalid_%0d", i), a_rvalid, 0);
      chk($sformatf("idle_b_rvalid_%0d", i), b_rvalid, 0);
    end
    a_req = 1'b1; b_req = 1'b1;
    #1;
    chk("idle_then_a_gnt", a_gnt, 1);
    chk("idle_then_b_gnt", b_gnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
